// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states
// and the conditional two's-complement negation used for sign fixup.
package mips_muldiv_pkg;

  localparam logic [2:0] MD_NOP   = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  // Widest vector the fixup helper handles; callers zero-extend in and truncate out,
  // which is exact for two's-complement negation.
  localparam int MD_WIDE_W = 128;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  function automatic logic [MD_WIDE_W-1:0] md_cond_neg(input logic [MD_WIDE_W-1:0] v,
                                                       input logic neg);
    return neg ? (~v + MD_WIDE_W'(1)) : v;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 iterative engine: shift-add multiply or restoring divide on unsigned
// magnitudes, one step per cycle through a single shared adder/subtractor.
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            run,
  input  logic            is_div,
  input  logic [XLEN:0]   a,
  input  logic [XLEN:0]   b,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo,
  output logic            last
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [XLEN:0]   upper_q, upper_d, opnd_q;
  logic [XLEN-1:0] lower_q, lower_d;
  logic            div_q;
  logic [CW-1:0]   count_q;
  logic [XLEN:0]   shifted, add_a, add_b, mul_sel;
  logic [XLEN+1:0] sum;

  // Divide subtracts via ~b + 1; the carry out of the extra top bit is "no borrow".
  always_comb begin
    shifted = {upper_q[XLEN-1:0], lower_q[XLEN-1]};
    add_a   = div_q ? shifted : upper_q;
    add_b   = div_q ? ~opnd_q : opnd_q;
    sum     = {1'b0, add_a} + {1'b0, add_b} + (XLEN+2)'(div_q);
    mul_sel = lower_q[0] ? sum[XLEN:0] : upper_q;
    if (div_q) begin
      if (sum[XLEN+1]) begin
        upper_d = sum[XLEN:0];
        lower_d = {lower_q[XLEN-2:0], 1'b1};
      end else begin
        upper_d = shifted;
        lower_d = {lower_q[XLEN-2:0], 1'b0};
      end
    end else begin
      upper_d = {1'b0, mul_sel[XLEN:1]};
      lower_d = {mul_sel[0], lower_q[XLEN-1:1]};
    end
    res_hi = upper_d[XLEN-1:0];
    res_lo = lower_d;
    last   = (count_q == CW'(XLEN - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upper_q <= '0;
      lower_q <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      count_q <= '0;
    end else if (start) begin
      upper_q <= '0;
      lower_q <= is_div ? a[XLEN-1:0] : b[XLEN-1:0];
      opnd_q  <= is_div ? b : a;
      div_q   <= is_div;
      count_q <= '0;
    end else if (run) begin
      upper_q <= upper_d;
      lower_q <= lower_d;
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// HI/LO registers plus multi-cycle MULT/MULTU/DIV/DIVU sequencing for the EX stage.
// Build option MULDIV_FAST_MUL_EN: multiplies complete in one cycle combinationally.
module muldiv_hilo_unit
  import mips_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs,
  input  logic [XLEN-1:0] rt,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  md_state_e         state_q, state_d;
  logic              accept, is_mul_op, is_div_op, signed_op;
  logic              start_iter, finish, rs_neg, rt_neg, last;
  logic [XLEN:0]     mag_rs, mag_rt;
  logic [XLEN-1:0]   res_hi, res_lo, quot_fix, rem_fix;
  logic [2*XLEN-1:0] prod_fix;
  logic              lat_div, lat_neg_hi, lat_neg_lo, lat_div0;
`ifdef MULDIV_FAST_MUL_EN
  logic              fast_mul;
  logic [2*XLEN-1:0] fast_prod;
`endif

  always_comb begin
    is_mul_op = (op == MD_MULT) || (op == MD_MULTU);
    is_div_op = (op == MD_DIV) || (op == MD_DIVU);
    signed_op = (op == MD_MULT) || (op == MD_DIV);
    accept    = op_valid && !busy && !flush;
`ifdef MULDIV_FAST_MUL_EN
    start_iter = accept && is_div_op;
    fast_mul   = accept && is_mul_op;
`else
    start_iter = accept && (is_mul_op || is_div_op);
`endif
    finish = (state_q == RUN) && last && !flush;
  end

  // Magnitudes are XLEN+1 bits so a MIN operand is represented exactly.
  always_comb begin
    rs_neg = signed_op && rs[XLEN-1];
    rt_neg = signed_op && rt[XLEN-1];
    mag_rs = rs_neg ? (~{1'b1, rs} + (XLEN+1)'(1)) : {1'b0, rs};
    mag_rt = rt_neg ? (~{1'b1, rt} + (XLEN+1)'(1)) : {1'b0, rt};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_iter) state_d = RUN;
      RUN:     if (flush || last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_iter),
    .run    (state_q == RUN),
    .is_div (is_div_op),
    .a      (mag_rs),
    .b      (mag_rt),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .last   (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_div    <= 1'b0;
      lat_neg_hi <= 1'b0;
      lat_neg_lo <= 1'b0;
      lat_div0   <= 1'b0;
    end else if (start_iter) begin
      lat_div    <= is_div_op;
      lat_neg_hi <= rs_neg;
      lat_neg_lo <= rs_neg ^ rt_neg;
      lat_div0   <= is_div_op && (rt == '0);
    end
  end

  // Remainder follows the dividend; divide-by-zero forces an all-ones quotient.
  always_comb begin
    prod_fix = (2*XLEN)'(md_cond_neg(MD_WIDE_W'({res_hi, res_lo}), lat_neg_lo));
    quot_fix = lat_div0 ? '1 : XLEN'(md_cond_neg(MD_WIDE_W'(res_lo), lat_neg_lo));
    rem_fix  = XLEN'(md_cond_neg(MD_WIDE_W'(res_hi), lat_neg_hi));
  end

`ifdef MULDIV_FAST_MUL_EN
  always_comb begin
    fast_prod = (2*XLEN)'(md_cond_neg(
                  MD_WIDE_W'((2*XLEN)'(mag_rs) * (2*XLEN)'(mag_rt)), rs_neg ^ rt_neg));
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
`ifdef MULDIV_FAST_MUL_EN
      done <= finish || fast_mul;
      if (fast_mul) {hi, lo} <= fast_prod;
`else
      done <= finish;
`endif
      if (accept && (op == MD_MTHI)) hi <= rs;
      if (accept && (op == MD_MTLO)) lo <= rs;
      if (finish) begin
        if (lat_div) begin
          hi <= rem_fix;
          lo <= quot_fix;
        end else begin
          {hi, lo} <= prod_fix;
        end
      end
    end
  end

endmodule
